// File: rtl/uart_buffered_tx_pkg.sv
// Purpose: shared types and constants for the buffered 8N1 UART transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_buffered_tx_pkg;

  localparam int DATA_W     = 8;
  localparam int FRAME_BITS = 10;  // start + 8 data + stop

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Purpose: DEPTH-entry synchronous byte FIFO feeding the UART serializer.
// Latency: a pushed byte is visible on dout (and empty drops) the cycle after the push.
// Backpressure: push accepted when !full or when a pop happens the same cycle; push_ok reports it.
// Ports: clk/rst (async active-low), push/din in, pop in, dout = head entry,
//        push_ok = push accepted this cycle, full/empty status.
module uart_tx_fifo
  import uart_buffered_tx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              push_ok,
  output logic              full,
  output logic              empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // A pop frees the slot being written, so a full FIFO can still take a byte.
  assign push_ok = push & (~full | pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      if (push_ok && !pop)      count <= count + CW'(1);
      else if (pop && !push_ok) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_buffered_tx.sv
// Purpose: buffered 8N1 UART transmitter; byte FIFO in front of a baud-timed serializer.
// Latency: push at edge N into an idle block -> pop and tx low from edge N+1; frame = 10*max(clk_div,1) clocks.
// Backpressure: pushes bounded by FIFO level; a push while full (no pop) is dropped and sets sticky overflow.
// Ports: clk, rst (async active-low), clk_div (clocks per bit, latched per frame),
//        tx_start/tx_data push strobe, clear_req accept pulse, tx serial line,
//        busy/full/empty status, ovf_clr/overflow, irq_en/irq (empty and idle).
module uart_buffered_tx
  import uart_buffered_tx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       clk_div,
  input  logic              tx_start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              clear_req,
  output logic              tx,
  output logic              busy,
  output logic              full,
  output logic              empty,
  input  logic              ovf_clr,
  output logic              overflow,
  input  logic              irq_en,
  output logic              irq
);

  tx_state_t         state, state_n;
  logic [31:0]       bc, bc_n;
  logic [31:0]       div_l, div_n;
  logic [2:0]        bit_idx, bit_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic              tx_q, tx_n;
  logic              pop, load, push_ok, bc_last;
  logic [DATA_W-1:0] fifo_dout;

  uart_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (tx_start),
    .din     (tx_data),
    .pop     (pop),
    .dout    (fifo_dout),
    .push_ok (push_ok),
    .full    (full),
    .empty   (empty)
  );

  assign bc_last = (bc == div_l - 32'd1);
  assign tx      = tx_q;
  assign busy    = (state != IDLE);
  assign irq     = irq_en & empty & ~busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      bc      <= '0;
      div_l   <= 32'd1;
      bit_idx <= '0;
      shreg   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state   <= state_n;
      bc      <= bc_n;
      div_l   <= div_n;
      bit_idx <= bit_n;
      shreg   <= shreg_n;
      tx_q    <= tx_n;
    end
  end

  always_comb begin
    state_n = state;
    bc_n    = bc;
    div_n   = div_l;
    bit_n   = bit_idx;
    shreg_n = shreg;
    tx_n    = tx_q;
    load    = 1'b0;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (!empty) load = 1'b1;
      end
      START: begin
        if (bc_last) begin
          state_n = DATA;
          bc_n    = '0;
          bit_n   = '0;
          tx_n    = shreg[0];
        end else begin
          bc_n = bc + 32'd1;
        end
      end
      DATA: begin
        if (bc_last) begin
          bc_n = '0;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            // tx is registered, so present the bit that becomes shreg[0] after the shift.
            shreg_n = shreg >> 1;
            bit_n   = bit_idx + 3'd1;
            tx_n    = shreg[1];
          end
        end else begin
          bc_n = bc + 32'd1;
        end
      end
      STOP: begin
        if (bc_last) begin
          bc_n = '0;
          if (!empty) begin
            load = 1'b1;  // back-to-back frame, no idle gap
          end else begin
            state_n = IDLE;
            tx_n    = 1'b1;
          end
        end else begin
          bc_n = bc + 32'd1;
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
    if (load) begin
      pop     = 1'b1;
      shreg_n = fifo_dout;
      div_n   = (clk_div == 32'd0) ? 32'd1 : clk_div;
      bc_n    = '0;
      state_n = START;
      tx_n    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clear_req <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      clear_req <= push_ok;
      if (ovf_clr)                  overflow <= 1'b0;
      else if (tx_start && !push_ok) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_buffered_tx.sv
// Purpose: self-checking bench for uart_buffered_tx (directed vectors plus multi-cycle sequences).
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_buffered_tx;
  import uart_buffered_tx_pkg::*;

  localparam int HN = 8192;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] clk_div = 32'd4;
  logic        tx_start = 1'b0;
  logic [7:0]  tx_data = 8'h00;
  logic        clear_req, tx, busy, full, empty, overflow, irq;
  logic        ovf_clr = 1'b0;
  logic        irq_en = 1'b0;

  uart_buffered_tx #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .clk_div   (clk_div),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .clear_req (clear_req),
    .tx        (tx),
    .busy      (busy),
    .full      (full),
    .empty     (empty),
    .ovf_clr   (ovf_clr),
    .overflow  (overflow),
    .irq_en    (irq_en),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  int   nchk = 0;
  int   nerr = 0;
  int   cyc  = 0;
  logic txh    [HN];
  logic busyh  [HN];
  logic emptyh [HN];
  logic irqh   [HN];

  // Per-cycle history of the outputs, sampled on the falling edge.
  always @(negedge clk) begin
    if (cyc < HN) begin
      txh[cyc]    = tx;
      busyh[cyc]  = busy;
      emptyh[cyc] = empty;
      irqh[cyc]   = irq;
    end
    cyc = cyc + 1;
  end

  typedef struct {
    logic [31:0] div;
    logic [7:0]  data;
    int          eff;
  } vec_t;
  vec_t vecs[4];

  task automatic check(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int find_fall(input int from);
    for (int i = from; i < cyc && i < HN; i++)
      if (txh[i] === 1'b0) return i;
    return -1;
  endfunction

  // Number of cycles in a frame starting at s whose tx/busy differ from an ideal 8N1 frame.
  function automatic int frame_err(input int s, input logic [7:0] d, input int div);
    int   e;
    int   b;
    logic exp_b;
    e = 0;
    for (int k = 0; k < FRAME_BITS * div; k++) begin
      b = k / div;
      if (b == 0)                   exp_b = 1'b0;
      else if (b == FRAME_BITS - 1) exp_b = 1'b1;
      else                          exp_b = d[b-1];
      if (s + k >= HN) e++;
      else if (txh[s+k] !== exp_b || busyh[s+k] !== 1'b1) e++;
    end
    return e;
  endfunction

  // Drive one push strobe; drop tx_start on the cycle clear_req is expected.
  task automatic push(input logic [7:0] d, input int exp_acc);
    @(negedge clk);
    tx_start = 1'b1;
    tx_data  = d;
    @(negedge clk);
    check("clear_req", int'(clear_req), exp_acc);
    tx_start = 1'b0;
  endtask

  initial begin
    int s, t0, t1, e;
    vecs[0] = '{32'd4, 8'hA5, 4};
    vecs[1] = '{32'd0, 8'h55, 1};
    vecs[2] = '{32'd1, 8'h55, 1};
    vecs[3] = '{32'd2, 8'hC3, 2};

    // Reset state
    #12;
    check("rst_tx", int'(tx), 1);
    check("rst_empty", int'(empty), 1);
    check("rst_full", int'(full), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_clear_req", int'(clear_req), 0);
    check("rst_irq_off", int'(irq), 0);
    irq_en = 1'b1;
    #1;
    check("rst_irq_on", int'(irq), 1);
    @(negedge clk);
    rst = 1'b1;

    // Single frames from the vector table
    for (int i = 0; i < 4; i++) begin
      e = vecs[i].eff;
      clk_div = vecs[i].div;
      t0 = cyc;
      push(vecs[i].data, 1);
      check($sformatf("v%0d_tx_idle", i), int'(tx), 1);
      check($sformatf("v%0d_not_empty", i), int'(empty), 0);
      check($sformatf("v%0d_not_busy", i), int'(busy), 0);
      @(negedge clk);
      check($sformatf("v%0d_start_latency", i), int'(tx), 0);
      check($sformatf("v%0d_busy", i), int'(busy), 1);
      check($sformatf("v%0d_clear_req_pulse", i), int'(clear_req), 0);
      repeat (FRAME_BITS * e + 5) @(negedge clk);
      s = find_fall(t0);
      check($sformatf("v%0d_fall_found", i), int'(s >= 0), 1);
      if (s >= 0) begin
        check($sformatf("v%0d_frame", i), frame_err(s, vecs[i].data, e), 0);
        check($sformatf("v%0d_end_tx", i), int'(txh[s + FRAME_BITS*e]), 1);
        check($sformatf("v%0d_end_busy", i), int'(busyh[s + FRAME_BITS*e]), 0);
        check($sformatf("v%0d_irq_in_stop", i), int'(irqh[s + FRAME_BITS*e - 1]), 0);
        check($sformatf("v%0d_irq_after", i), int'(irqh[s + FRAME_BITS*e]), 1);
      end
    end

    // Three back-to-back frames at clk_div=3
    clk_div = 32'd3;
    t0 = cyc;
    push(8'h01, 1);
    push(8'h80, 1);
    push(8'hFF, 1);
    check("t2_queued", int'(empty), 0);
    repeat (100) @(negedge clk);
    s = find_fall(t0);
    check("t2_fall_found", int'(s >= 0), 1);
    if (s >= 0) begin
      check("t2_frame0", frame_err(s, 8'h01, 3), 0);
      check("t2_frame1", frame_err(s + 30, 8'h80, 3), 0);
      check("t2_frame2", frame_err(s + 60, 8'hFF, 3), 0);
      check("t2_empty_before_pop3", int'(emptyh[s + 59]), 0);
      check("t2_empty_at_pop3", int'(emptyh[s + 60]), 1);
      check("t2_end_tx", int'(txh[s + 90]), 1);
      check("t2_end_busy", int'(busyh[s + 90]), 0);
    end

    // Fill FIFO, overflow, ovf_clr priority
    clk_div = 32'd16;
    t0 = cyc;
    push(8'h11, 1);
    push(8'h22, 1);
    push(8'h33, 1);
    push(8'h44, 1);
    check("t3_not_full_yet", int'(full), 0);
    push(8'h55, 1);
    check("t3_full", int'(full), 1);
    push(8'h66, 0);
    check("t3_overflow_set", int'(overflow), 1);
    check("t3_still_full", int'(full), 1);
    @(negedge clk);
    tx_start = 1'b1;
    tx_data  = 8'h77;
    ovf_clr  = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    ovf_clr  = 1'b0;
    check("t3_ovf_clr_priority", int'(overflow), 0);
    check("t3_drop_no_clear_req", int'(clear_req), 0);
    push(8'h88, 0);
    check("t3_overflow_again", int'(overflow), 1);
    @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("t3_ovf_cleared", int'(overflow), 0);
    repeat (5 * 160 + 20) @(negedge clk);
    s = find_fall(t0);
    check("t3_fall_found", int'(s >= 0), 1);
    if (s >= 0) begin
      check("t3_frame0", frame_err(s, 8'h11, 16), 0);
      check("t3_frame1", frame_err(s + 160, 8'h22, 16), 0);
      check("t3_frame2", frame_err(s + 320, 8'h33, 16), 0);
      check("t3_frame3", frame_err(s + 480, 8'h44, 16), 0);
      check("t3_frame4", frame_err(s + 640, 8'h55, 16), 0);
      check("t3_end_busy", int'(busyh[s + 800]), 0);
      check("t3_no_sixth", find_fall(s + 800), -1);
    end

    // Reset in the middle of data bit 4
    clk_div = 32'd8;
    push(8'h3C, 1);
    // Now one cycle before the start bit; bit 4 occupies frame cycles 40..47.
    repeat (45) @(negedge clk);
    check("t4_busy_mid_frame", int'(busy), 1);
    check("t4_tx_bit4", int'(tx), 1);
    #2;
    rst = 1'b0;
    #1;
    check("t4_rst_tx", int'(tx), 1);
    check("t4_rst_empty", int'(empty), 1);
    check("t4_rst_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b1;
    t1 = cyc;
    repeat (100) @(negedge clk);
    check("t4_no_frame_after_rst", find_fall(t1), -1);
    check("t4_still_empty", int'(empty), 1);

    // clk_div change mid-frame with a second byte queued
    clk_div = 32'd4;
    t0 = cyc;
    push(8'h5A, 1);
    push(8'hC3, 1);
    @(negedge clk);
    clk_div = 32'd8;
    repeat (130) @(negedge clk);
    s = find_fall(t0);
    check("t6_fall_found", int'(s >= 0), 1);
    if (s >= 0) begin
      check("t6_frame_div4", frame_err(s, 8'h5A, 4), 0);
      check("t6_frame_div8", frame_err(s + 40, 8'hC3, 8), 0);
      check("t6_end_tx", int'(txh[s + 120]), 1);
      check("t6_end_busy", int'(busyh[s + 120]), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/uart_buffered_tx.md
Name: uart_buffered_tx

Overview:
Buffered 8N1 UART transmitter with a DEPTH-entry byte FIFO in front of the serializer.
- Firmware pushes bytes with a tx_start/tx_data strobe, bounded by the FIFO level rather than by the line.
- The block streams frames back-to-back on tx at clk_div clocks per bit.
- Sits beside uart_receive under the uart top and takes the same clk_div (clk_freq / BAUD_RATE).

Parameters:
DEPTH, 4, FIFO entries; power of two, >= 2; pointer width = log2(DEPTH), count width = log2(DEPTH)+1

Ports:
clk  input  1  system clock; all state on rising edge
rst  input  1  asynchronous, active-low reset
clk_div  input  32  clocks per bit; sampled at each frame start
tx_start  input  1  push strobe; one push per high cycle
tx_data  input  8  byte pushed when tx_start is accepted
clear_req  output  1  one-cycle pulse the cycle after a push is accepted; firmware drops tx_start on it
tx  output  1  serial line; idle high
busy  output  1  high while a frame is on the line (state != IDLE)
full  output  1  count == DEPTH
empty  output  1  count == 0
ovf_clr  input  1  clears the overflow flag
overflow  output  1  sticky; set when a push is dropped
irq_en  input  1  enables irq
irq  output  1  level; irq_en & empty & !busy

Behaviour:
- Reset (rst low, async):
  - tx=1; state=IDLE; FIFO pointers and count = 0; overflow=0; clear_req=0; bit and baud counters = 0.
  - Derived outputs follow: empty=1, full=0, busy=0, irq=irq_en.
- Reset mid-frame aborts the frame: tx returns to 1 immediately and queued data is discarded.
- Push rules:
  - Push accepted when tx_start & (!full | pop).
  - Push while full with no pop that cycle: byte dropped, overflow set to 1, no clear_req.
  - ovf_clr has priority over a same-cycle overflow set.
- Pop occurs on the cycle the serializer loads a byte (IDLE->START or STOP->START).
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo DEPTH.
- Serializer FSM, with baud counter bc counting 0..div_l-1:
  - IDLE: tx=1. If !empty: pop the FIFO head into shreg, latch div_l = max(clk_div, 1), bc=0, go to START.
  - START: tx=0 for div_l cycles, then go to DATA with bit index 0.
  - DATA: tx=shreg[0], LSB first. Each bit is held div_l cycles, then shreg shifts right. After bit 7, go to STOP.
  - STOP: tx=1 for div_l cycles. Then, if !empty, pop and go straight to START with no idle gap; otherwise go to IDLE.
- Frame length is exactly 10*div_l clocks.
- tx is driven from a register (glitch-free).
- Latency: push accepted at edge N with FIFO empty and IDLE:
  - FIFO non-empty after N;
  - pop and START entry at N+1;
  - tx low from edge N+1, i.e. the first falling tx is visible in the cycle after N+1.
- A clk_div change mid-frame has no effect until the next frame start.
- clk_div=0 behaves as 1.
- DEPTH bytes may be queued while a frame is in flight; DEPTH+1 bytes in flight in total.

Decomposition:
- Shared package: state encoding (IDLE, START, DATA, STOP), DATA_W=8, FRAME_BITS=10.
- One natural sub-module: uart_tx_fifo (synchronous FIFO: push/pop, full/empty, count, parameter DEPTH).
- The FSM and baud counter stay in uart_buffered_tx.

Test Plan:
1. clk_div=4, push 0xA5 once -> clear_req pulses one cycle; tx = 0, then 1,0,1,0,0,1,0,1 (LSB first), then 1; each level 4 clocks; 40 clocks total; busy high throughout; irq rises after stop when irq_en=1.
2. clk_div=3, push 0x01, 0x80, 0xFF on consecutive opportunities -> three frames of 30 clocks each, no idle gap between stop and the next start; empty asserts at the third pop.
3. DEPTH=4, clk_div=16, push 6 bytes back-to-back -> the first pops immediately and 4 fill the FIFO (full=1); the 6th is dropped, overflow=1, no clear_req for it. Only 5 frames are transmitted; ovf_clr pulse clears overflow.
4. clk_div=8, push 0x3C, assert rst low mid-DATA bit 4 -> tx=1 asynchronously, empty=1, busy=0. After release, no frame is transmitted.
5. clk_div=0 and clk_div=1, push 0x55 -> 10-clock frame, alternating bits 1 clock each.
6. Change clk_div 4->8 during a frame, with a second byte queued -> first frame 40 clocks, second frame 80 clocks.
